// File: rtl/multistart_sweep_ctrl.sv
// multistart_sweep_ctrl: runs NUM_STARTS solver jobs from LFSR start points and keeps the global minimum
module multistart_sweep_ctrl #(
  parameter int NUM_STARTS     = 8,
  parameter int START_MIN      = -64,
  parameter int START_MAX      = 63,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sweep_start,
  input  logic [31:0] seed,
  output logic        start_op,
  output logic [7:0]  a_initial,
  output logic [7:0]  b_initial,
  output logic [7:0]  c_initial,
  output logic [7:0]  d_initial,
  input  logic        solver_done,
  input  logic [31:0] solver_z_min,
  input  logic [7:0]  solver_a,
  input  logic [7:0]  solver_b,
  input  logic [7:0]  solver_c,
  input  logic [7:0]  solver_d,
  output logic [31:0] best_z,
  output logic [7:0]  best_a,
  output logic [7:0]  best_b,
  output logic [7:0]  best_c,
  output logic [7:0]  best_d,
  output logic [7:0]  best_idx,
  output logic        busy,
  output logic        sweep_done,
  output logic        timeout_seen
);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic signed [7:0] LO = 8'(START_MIN);
  localparam logic signed [7:0] HI = 8'(START_MAX);
  localparam logic [31:0] TAPS = 32'h8020_0003;
  localparam logic [31:0] Z_INIT = 32'h7FFF_FFFF;
  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT, CAPTURE, RELEASE, NEXT, DONE} state_t;
  state_t state, state_d;
  logic [31:0] lfsr, lfsr_d, best_z_d;
  logic [7:0] run_idx, run_idx_d, best_idx_d;
  logic [WW-1:0] wait_cnt, wait_cnt_d;
  logic [7:0] a_d, b_d, c_d, d_d, ba_d, bb_d, bc_d, bd_d;
  logic start_op_d, busy_d, sweep_done_d, timeout_seen_d;
  function automatic logic [7:0] clamp(input logic signed [7:0] v);
    return v < LO ? LO : (v > HI ? HI : v);
  endfunction
  always_comb begin
    state_d = state;
    lfsr_d = lfsr;
    run_idx_d = run_idx;
    wait_cnt_d = wait_cnt;
    start_op_d = start_op;
    a_d = a_initial;
    b_d = b_initial;
    c_d = c_initial;
    d_d = d_initial;
    best_z_d = best_z;
    best_idx_d = best_idx;
    ba_d = best_a;
    bb_d = best_b;
    bc_d = best_c;
    bd_d = best_d;
    timeout_seen_d = timeout_seen;
    case (state)
      IDLE: state_d = sweep_start ? LOAD : IDLE;
      LOAD: begin
        lfsr_d = (seed == '0) ? 32'h1 : seed;
        best_z_d = Z_INIT;
        best_idx_d = '0;
        {ba_d, bb_d, bc_d, bd_d} = '0;
        run_idx_d = '0;
        timeout_seen_d = 1'b0;
        state_d = ISSUE;
      end
      ISSUE: begin
        a_d = clamp(lfsr[7:0]);
        b_d = clamp(lfsr[15:8]);
        c_d = clamp(lfsr[23:16]);
        d_d = clamp(lfsr[31:24]);
        start_op_d = 1'b1;
        wait_cnt_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        wait_cnt_d = wait_cnt + 1'b1;
        if (solver_done)
          state_d = CAPTURE;
        else if (wait_cnt == WW'(TIMEOUT_CYCLES - 1)) begin
          start_op_d = 1'b0;
          timeout_seen_d = 1'b1;
          state_d = RELEASE;
        end
      end
      CAPTURE: begin
        if ($signed(solver_z_min) < $signed(best_z)) begin
          best_z_d = solver_z_min;
          {ba_d, bb_d, bc_d, bd_d} = {solver_a, solver_b, solver_c, solver_d};
          best_idx_d = run_idx;
        end
        start_op_d = 1'b0;
        state_d = RELEASE;
      end
      // a stale done must clear before the next run may be issued
      RELEASE: state_d = solver_done ? RELEASE : NEXT;
      NEXT: begin
        lfsr_d = (lfsr >> 1) ^ (lfsr[0] ? TAPS : 32'h0);
        run_idx_d = run_idx + 1'b1;
        state_d = (run_idx == 8'(NUM_STARTS - 1)) ? DONE : ISSUE;
      end
      DONE: state_d = sweep_start ? DONE : IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = !(state_d inside {IDLE, DONE});
    sweep_done_d = state_d == DONE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      lfsr <= 32'h1;
      run_idx <= '0;
      wait_cnt <= '0;
      start_op <= 1'b0;
      {a_initial, b_initial, c_initial, d_initial} <= '0;
      best_z <= Z_INIT;
      best_idx <= '0;
      {best_a, best_b, best_c, best_d} <= '0;
      busy <= 1'b0;
      sweep_done <= 1'b0;
      timeout_seen <= 1'b0;
    end else begin
      state <= state_d;
      lfsr <= lfsr_d;
      run_idx <= run_idx_d;
      wait_cnt <= wait_cnt_d;
      start_op <= start_op_d;
      {a_initial, b_initial, c_initial, d_initial} <= {a_d, b_d, c_d, d_d};
      best_z <= best_z_d;
      best_idx <= best_idx_d;
      {best_a, best_b, best_c, best_d} <= {ba_d, bb_d, bc_d, bd_d};
      busy <= busy_d;
      sweep_done <= sweep_done_d;
      timeout_seen <= timeout_seen_d;
    end
  end
endmodule

// File: tb/tb_multistart_sweep_ctrl.sv
// tb_multistart_sweep_ctrl: randomized sweeps against a behavioural solver and a best-of-runs reference model
module tb_multistart_sweep_ctrl;
  localparam int NS = 4;
  localparam int TMO = 16;
  logic clk = 1'b0, rst_n = 1'b0, sweep_start = 1'b0;
  logic [31:0] seed = '0;
  logic start_op, solver_done, busy, sweep_done, timeout_seen;
  logic [7:0] a_initial, b_initial, c_initial, d_initial;
  logic [31:0] solver_z_min, best_z;
  logic [7:0] solver_a, solver_b, solver_c, solver_d;
  logic [7:0] best_a, best_b, best_c, best_d, best_idx;
  int checks = 0, failures = 0;
  int g_mode, g_hang = -1, g_lat = 4;
  logic [31:0] m_lfsr, first_init;
  int m_run;
  logic [31:0] r_z [NS];
  logic [31:0] r_abcd [NS];
  bit r_to [NS];
  multistart_sweep_ctrl #(.NUM_STARTS(NS), .START_MIN(-64), .START_MAX(63), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .sweep_start(sweep_start), .seed(seed),
    .start_op(start_op), .a_initial(a_initial), .b_initial(b_initial),
    .c_initial(c_initial), .d_initial(d_initial),
    .solver_done(solver_done), .solver_z_min(solver_z_min),
    .solver_a(solver_a), .solver_b(solver_b), .solver_c(solver_c), .solver_d(solver_d),
    .best_z(best_z), .best_a(best_a), .best_b(best_b), .best_c(best_c), .best_d(best_d),
    .best_idx(best_idx), .busy(busy), .sweep_done(sweep_done), .timeout_seen(timeout_seen)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] step(input logic [31:0] l);
    return (l >> 1) ^ (l[0] ? 32'h8020_0003 : 32'h0);
  endfunction
  function automatic logic [7:0] cl(input logic [7:0] b);
    int v;
    v = int'($signed(b));
    v = v < -64 ? -64 : (v > 63 ? 63 : v);
    return 8'(v);
  endfunction
  function automatic int sq(input logic [7:0] b);
    int v;
    v = int'($signed(b));
    return v * v;
  endfunction
  // behavioural solver: answers g_lat cycles after start_op rises, never answers run g_hang
  initial begin
    int cyc, t_rise, cur;
    bit armed;
    logic [31:0] abcd, z;
    solver_done = 0; solver_z_min = 0;
    {solver_a, solver_b, solver_c, solver_d} = '0;
    cyc = 0; t_rise = 0; cur = 0; armed = 0; z = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n || !start_op) begin
        if (armed && rst_n && cur == g_hang) check("timeout_lat", cyc - t_rise, TMO);
        armed = 0;
        solver_done = 0;
      end else if (!armed && !solver_done) begin
        armed = 1; t_rise = cyc; cur = m_run;
        abcd = {a_initial, b_initial, c_initial, d_initial};
        check("init_point", abcd, {cl(m_lfsr[7:0]), cl(m_lfsr[15:8]), cl(m_lfsr[23:16]), cl(m_lfsr[31:24])});
        if (cur == 0) first_init = abcd;
        z = g_mode == 0 ? ((sq(a_initial) + sq(b_initial) + sq(c_initial) + sq(d_initial)) << 8) :
            g_mode == 1 ? 32'h0000_0100 :
            ((cur > 0 && cur < NS && $urandom_range(0, 3) == 0) ? r_z[cur - 1] : $urandom);
        if (cur < NS) begin
          r_z[cur] = z;
          r_abcd[cur] = $urandom;
          r_to[cur] = cur == g_hang;
        end
        m_lfsr = step(m_lfsr);
        m_run++;
      end else if (armed && cur != g_hang && cyc - t_rise >= g_lat) begin
        armed = 0;
        solver_done = 1;
        solver_z_min = z;
        {solver_a, solver_b, solver_c, solver_d} = cur < NS ? r_abcd[cur] : 32'h0;
      end
    end
  end
  task automatic run_sweep(input logic [31:0] s, input int mode, input int hang, input int lat,
                           input bit chk_first, input logic [31:0] first_exp, input int hold, input int abort_at);
    logic signed [31:0] bz;
    int bi;
    logic [31:0] bc;
    bit to;
    g_mode = mode; g_hang = hang; g_lat = lat;
    for (int i = 0; i < NS; i++) begin
      r_z[i] = 0; r_abcd[i] = 0; r_to[i] = 0;
    end
    m_lfsr = (s == 0) ? 32'h1 : s;
    m_run = 0;
    seed = s;
    sweep_start = 1;
    repeat (3) @(negedge clk);
    check("busy_run", busy, 1);
    check("to_cleared", timeout_seen, 0);
    if (abort_at >= 0) begin
      for (int i = 0; i < 1000 && m_run <= abort_at; i++) @(negedge clk);
      check("reach_abort", m_run, abort_at + 1);
      repeat (3) @(negedge clk);
      rst_n = 0; sweep_start = 0;
      @(negedge clk);
      rst_n = 1;
      check("abort_start_op", start_op, 0);
      check("abort_best_z", best_z, 32'h7FFF_FFFF);
      check("abort_busy", busy, 0);
      check("abort_idx", best_idx, 0);
      check("abort_to", timeout_seen, 0);
      return;
    end
    for (int i = 0; i < 3000 && !sweep_done; i++) @(negedge clk);
    check("sweep_done", sweep_done, 1);
    repeat (hold) @(negedge clk);
    check("done_held", sweep_done, 1);
    check("run_count", m_run, NS);
    bz = 32'sh7FFF_FFFF; bi = 0; bc = 0; to = 0;
    for (int i = 0; i < NS; i++)
      if (r_to[i]) to = 1;
      else if ($signed(r_z[i]) < bz) begin
        bz = r_z[i]; bi = i; bc = r_abcd[i];
      end
    check("best_z", best_z, bz);
    check("best_idx", best_idx, bi);
    check("best_abcd", {best_a, best_b, best_c, best_d}, bc);
    check("timeout_seen", timeout_seen, to);
    check("busy_done", busy, 0);
    if (chk_first) check("first_init", first_init, first_exp);
    sweep_start = 0;
    repeat (2) @(negedge clk);
    check("idle_done_low", sweep_done, 0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end
  initial begin
    logic [31:0] s;
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    check("rst_start_op", start_op, 0);
    check("rst_busy", busy, 0);
    check("rst_sweep_done", sweep_done, 0);
    check("rst_best_z", best_z, 32'h7FFF_FFFF);
    check("rst_best_idx", best_idx, 0);
    check("rst_timeout", timeout_seen, 0);
    check("rst_init", {a_initial, b_initial, c_initial, d_initial}, 0);
    check("rst_best_abcd", {best_a, best_b, best_c, best_d}, 0);
    run_sweep(32'h1234_5678, 0, -1, 8, 1, 32'h3F3F_3412, 0, -1);
    run_sweep(32'h0, 2, -1, 5, 1, 32'h0100_0000, 0, -1);
    run_sweep($urandom, 1, -1, 3, 0, 0, 0, -1);
    run_sweep(32'h1234_5678, 0, 1, 6, 1, 32'h3F3F_3412, 30, -1);
    run_sweep($urandom, 2, -1, 7, 0, 0, 0, -1);
    s = $urandom;
    run_sweep(s, 0, -1, 12, 0, 0, 0, 2);
    run_sweep(s, 0, -1, 4, 1, {cl(s[7:0]), cl(s[15:8]), cl(s[23:16]), cl(s[31:24])}, 0, -1);
    for (int k = 0; k < 6; k++)
      run_sweep($urandom, int'($urandom_range(0, 2)),
                $urandom_range(0, 2) == 0 ? int'($urandom_range(0, NS - 1)) : -1,
                int'($urandom_range(1, 12)), 0, 0, int'($urandom_range(0, 5)), -1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
